// File: rtl/projection_sequencer.sv
// Perspective-projects each vertex of a RAM-held list via one shared divider: X, then Y.
// Point latency 3 + 2*(divider latency + 1) cycles (3 if clipped); holds all out_* while out_ready=0.
module projection_sequencer #(
  parameter int NUM_VERTS = 8,
  parameter int ADDR_W    = 3,
  parameter int COORD_W   = 16,
  parameter int VANISH_Z  = -10,
  parameter int Z_DIST    = 20,
  parameter int SCALE     = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      vert_addr,
  input  logic [COORD_W-1:0]     vert_x,
  input  logic [COORD_W-1:0]     vert_y,
  input  logic [COORD_W-1:0]     vert_z,
  output logic                   div_start,
  output logic [2*COORD_W-1:0]   div_num,
  output logic [COORD_W+1:0]     div_den,
  input  logic                   div_done,
  input  logic [2*COORD_W-1:0]   div_quot,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COORD_W-1:0]     out_x,
  output logic [COORD_W-1:0]     out_y,
  output logic [ADDR_W-1:0]      out_idx,
  output logic                   out_clip
);

  localparam int NUM_W = 2 * COORD_W;
  localparam int DEN_W = COORD_W + 2;
  localparam logic signed [NUM_W-1:0] NUM_K   = NUM_W'(SCALE * VANISH_Z);
  localparam logic signed [DEN_W-1:0] DEN_OFS = DEN_W'(Z_DIST + VANISH_Z);
  localparam logic [ADDR_W-1:0]       LAST    = ADDR_W'(NUM_VERTS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_DIVX_REQ, S_DIVX_WAIT,
    S_DIVY_REQ, S_DIVY_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [ADDR_W-1:0]   vert_addr_q, vert_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                div_start_q, div_start_d;
  logic [NUM_W-1:0]    div_num_q, div_num_d;
  logic [DEN_W-1:0]    div_den_q, div_den_d;
  logic [NUM_W-1:0]    num_y_q, num_y_d;
  logic                out_valid_q, out_valid_d;
  logic [COORD_W-1:0]  out_x_q, out_x_d;
  logic [COORD_W-1:0]  out_y_q, out_y_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
  logic                out_clip_q, out_clip_d;

  logic signed [NUM_W-1:0] num_x, num_y;
  logic signed [DEN_W-1:0] den;
  logic                    den_le_zero;
  logic                    unused_quot_hi;

  // Numerators are formed at full width so no product can overflow.
  always_comb begin
    num_x       = NUM_K * $signed({{COORD_W{vert_x[COORD_W-1]}}, vert_x});
    num_y       = NUM_K * $signed({{COORD_W{vert_y[COORD_W-1]}}, vert_y});
    den         = $signed({{2{vert_z[COORD_W-1]}}, vert_z}) + DEN_OFS;
    den_le_zero = den[DEN_W-1] || (den == '0);
  end

  assign unused_quot_hi = ^div_quot[NUM_W-1:COORD_W];

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    vert_addr_d = vert_addr_q;
    done_d      = 1'b0;
    div_start_d = 1'b0;
    div_num_d   = div_num_q;
    div_den_d   = div_den_q;
    num_y_d     = num_y_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_idx_d   = out_idx_q;
    out_clip_d  = out_clip_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d     = '0;
          vert_addr_d = '0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        num_y_d = num_y;
        if (den_le_zero) begin
          out_clip_d  = 1'b1;
          out_x_d     = '0;
          out_y_d     = '0;
          out_valid_d = 1'b1;
          out_idx_d   = index_q;
          state_d     = S_EMIT;
        end else begin
          div_start_d = 1'b1;
          div_num_d   = num_x;
          div_den_d   = den;
          state_d     = S_DIVX_REQ;
        end
      end
      S_DIVX_REQ: state_d = S_DIVX_WAIT;
      S_DIVX_WAIT: begin
        if (div_done) begin
          out_x_d     = div_quot[COORD_W-1:0];
          div_start_d = 1'b1;
          div_num_d   = num_y_q;
          state_d     = S_DIVY_REQ;
        end
      end
      S_DIVY_REQ: state_d = S_DIVY_WAIT;
      S_DIVY_WAIT: begin
        if (div_done) begin
          out_y_d     = div_quot[COORD_W-1:0];
          out_valid_d = 1'b1;
          out_idx_d   = index_q;
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_clip_d  = 1'b0;
          if (index_q == LAST) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            index_d     = index_q + 1'b1;
            vert_addr_d = index_q + 1'b1;
            state_d     = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // busy stays high through the DONE cycle and drops on return to IDLE.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      vert_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
      div_num_q   <= '0;
      div_den_q   <= '0;
      num_y_q     <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_idx_q   <= '0;
      out_clip_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      vert_addr_q <= vert_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_start_q <= div_start_d;
      div_num_q   <= div_num_d;
      div_den_q   <= div_den_d;
      num_y_q     <= num_y_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_idx_q   <= out_idx_d;
      out_clip_q  <= out_clip_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign vert_addr = vert_addr_q;
  assign div_start = div_start_q;
  assign div_num   = div_num_q;
  assign div_den   = div_den_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_idx   = out_idx_q;
  assign out_clip  = out_clip_q;

endmodule

// File: tb/tb_projection_sequencer.sv
// Scoreboard bench for projection_sequencer with vertex-RAM and variable-latency divider models.
// Expected points are computed from the vertex tables when a pass starts and popped on each handshake.
module tb_projection_sequencer;

  localparam int NV = 8;
  localparam int VZ = -10;
  localparam int ZD = 20;

  logic        clock = 1'b0;
  logic        reset, start;
  logic        busy, done;
  logic [2:0]  vert_addr;
  logic [15:0] vert_x, vert_y, vert_z;
  logic        div_start;
  logic [31:0] div_num;
  logic [17:0] div_den;
  logic        div_done;
  logic [31:0] div_quot;
  logic        out_valid, out_ready;
  logic [15:0] out_x, out_y;
  logic [2:0]  out_idx;
  logic        out_clip;

  projection_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .vert_addr(vert_addr), .vert_x(vert_x), .vert_y(vert_y), .vert_z(vert_z),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_done(div_done), .div_quot(div_quot),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_idx(out_idx), .out_clip(out_clip)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  idx;
    logic        clip;
  } pt_t;

  pt_t exp_q[$];
  int  vx[NV], vy[NV], vz[NV];
  int  errors = 0;
  int  checks = 0;
  int  div_lat = 4;
  int  ds_cnt = 0;
  bit  div_abort = 0;
  bit  bp_arm = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pt_t exp_pt(input int i);
    pt_t p;
    longint den, nx, ny;
    den = longint'(vz[i]) + ZD + VZ;
    nx  = longint'(VZ) * vx[i];
    ny  = longint'(VZ) * vy[i];
    p.idx = 3'(i);
    if (den <= 0) begin
      p.clip = 1'b1; p.x = '0; p.y = '0;
    end else begin
      p.clip = 1'b0; p.x = 16'(nx / den); p.y = 16'(ny / den);
    end
    return p;
  endfunction

  // Synchronous vertex RAM: data follows the registered address half a cycle later.
  initial forever begin
    @(negedge clock);
    vert_x = 16'(vx[vert_addr]);
    vert_y = 16'(vy[vert_addr]);
    vert_z = 16'(vz[vert_addr]);
  end

  // Divider: div_done arrives div_lat cycles after div_start, operands checked every waiting cycle.
  initial begin
    logic [31:0] n;
    logic [17:0] d;
    div_done = 1'b0;
    div_quot = '0;
    forever begin
      @(negedge clock);
      while (div_start) begin
        n = div_num;
        d = div_den;
        for (int i = 0; i < div_lat; i++) begin
          @(negedge clock);
          if (!div_abort) begin
            chk("div_num_hold", div_num, n);
            chk("div_den_hold", div_den, d);
            chk("div_no_overlap", div_start, 0);
          end
        end
        div_quot = 32'($signed(n) / $signed(d));
        div_done = 1'b1;
        @(negedge clock);
        div_done = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (div_start) ds_cnt++;
  end

  // Scoreboard consumer: a handshake happens at the posedge following this negedge.
  initial forever begin
    @(negedge clock);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_point", 1, 0);
      end else begin
        pt_t e;
        e = exp_q.pop_front();
        chk("pt_x", out_x, e.x);
        chk("pt_y", out_y, e.y);
        chk("pt_idx", out_idx, e.idx);
        chk("pt_clip", out_clip, e.clip);
      end
    end
  end

  // Backpressure: hold out_ready low for 5 cycles on vertex 2 and require frozen outputs.
  initial begin
    logic [39:0] snap;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (bp_arm && out_valid && out_idx == 3'd2) begin
        bp_arm = 0;
        out_ready = 1'b0;
        snap = {out_x, out_y, out_idx, out_clip, out_valid, vert_addr};
        repeat (5) begin
          @(posedge clock);
          #1;
          chk("bp_stable", {out_x, out_y, out_idx, out_clip, out_valid, vert_addr}, snap);
        end
        out_ready = 1'b1;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {busy, done, vert_addr, div_start, out_valid, out_idx, out_clip}, 0);
    chk({tag, "_div"}, {div_num, div_den}, 0);
    chk({tag, "_xy"}, {out_x, out_y}, 0);
  endtask

  task automatic load_a();
    vx = '{5, 7, -7, 7, 100, 3000, 4000, 32767};
    vy = '{3, 7, 7, 7, -200, -3000, 1, -32767};
    vz = '{0, -10, -7, -15, 5, -9, 0, -9};
  endtask

  task automatic load_b();
    vx = '{1, -4, 11, 250, -1, 6, -32768, 9};
    vy = '{2, 9, -13, -250, -1, 6, 32767, -9};
    vz = '{0, 5, -8, 3, 20, -9, 100, 1};
  endtask

  task automatic run_pass(input int lat, input bit bp, input bit extra);
    int  ds0, nclip, cyc, exp_lat;
    bit  got;
    pt_t p;
    div_lat = lat;
    bp_arm  = bp;
    ds0     = ds_cnt;
    nclip   = 0;
    for (int i = 0; i < NV; i++) begin
      p = exp_pt(i);
      if (p.clip) nclip++;
      exp_q.push_back(p);
    end
    exp_lat = exp_q[0].clip ? 3 : 3 + 2 * (lat + 1);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1);
    while (!out_valid && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
    chk("first_latency", cyc, exp_lat);
    if (extra) begin
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (done) got = 1;
      else @(negedge clock);
    end
    chk("done_seen", got, 1);
    if (got && extra) start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_fall", busy, 0);
    chk("done_one_cycle", done, 0);
    if (extra) begin
      repeat (3) @(negedge clock);
      chk("start_in_done_ignored", busy, 0);
    end
    chk("queue_empty", exp_q.size(), 0);
    chk("div_start_count", ds_cnt - ds0, 2 * (NV - nclip));
  endtask

  initial begin
    int  base, seen_valid, seen_done;
    bit  reached;
    reset = 1'b1;
    start = 1'b0;
    load_a();
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    check_all_zero("idle");

    // Mixed table: clipping at den=0 and den<0, truncation toward zero, low-bit wrap.
    run_pass(4, 0, 0);
    // All-unclipped table with backpressure and ignored start pulses.
    load_b();
    run_pass(1, 1, 1);
    run_pass(20, 0, 0);

    // Reset during the Y division of vertex 0; the late div_done must be ignored.
    div_lat = 20;
    base = ds_cnt;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (ds_cnt - base >= 2) reached = 1;
      else @(negedge clock);
    end
    chk("reach_divy_wait", reached, 1);
    repeat (3) @(negedge clock);
    div_abort = 1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_all_zero("midpass_reset");
    @(negedge clock);
    reset = 1'b0;
    seen_valid = 0;
    seen_done  = 0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid) seen_valid++;
      if (done) seen_done++;
    end
    chk("late_div_no_output", seen_valid, 0);
    chk("late_div_no_done", seen_done, 0);
    chk("after_reset_idle", busy, 0);
    div_abort = 0;

    load_a();
    run_pass(1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
